// File: rtl/clock_pkg.sv
// Shared mode encodings and the ms-prescaler divisor helper for the digital clock.
package clock_pkg;

    localparam logic [1:0] MODE_RUN      = 2'd0;
    localparam logic [1:0] MODE_SET_HOUR = 2'd1;
    localparam logic [1:0] MODE_SET_MIN  = 2'd2;

    function automatic int MS_DIV(input int clk_freq);
        return clk_freq / 1000;
    endfunction

endpackage

// File: rtl/key_autorepeat.sv
// INC key stepper: one pulse on the press edge, then auto-repeat while the key stays held.
module key_autorepeat
    import clock_pkg::*;
#(
    parameter int REPEAT_DLY_MS  = 500,
    parameter int REPEAT_RATE_MS = 100,
    parameter int CNT_W          = 14
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic ms_tick_i,
    input  logic lvl_i,
    input  logic clr_i,
    output logic pulse_o
);

    localparam logic [CNT_W-1:0] DLY_C  = CNT_W'(REPEAT_DLY_MS);
    localparam logic [CNT_W-1:0] RATE_C = CNT_W'(REPEAT_RATE_MS);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

    logic             lvl_q;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] dly_q, dly_d;
    logic [CNT_W-1:0] rate_q, rate_d;

    // The press cycle itself never counts toward the hold delay; only ticks with the key already held do.
    always_comb begin
        dly_d   = dly_q;
        rate_d  = rate_q;
        pulse_d = 1'b0;
        if (clr_i || !lvl_i) begin
            dly_d  = '0;
            rate_d = '0;
        end else if (!lvl_q) begin
            pulse_d = 1'b1;
        end else if (ms_tick_i) begin
            if (dly_q != DLY_C) begin
                dly_d   = dly_q + ONE_C;
                pulse_d = (dly_d == DLY_C);
            end else begin
                rate_d = rate_q + ONE_C;
                if (rate_d == RATE_C) begin
                    rate_d  = '0;
                    pulse_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lvl_q   <= 1'b0;
            pulse_q <= 1'b0;
            dly_q   <= '0;
            rate_q  <= '0;
        end else begin
            lvl_q   <= lvl_i;
            pulse_q <= pulse_d;
            dly_q   <= dly_d;
            rate_q  <= rate_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: RUN/SET_HOUR/SET_MIN mode FSM, inactivity timeout, blink gating and the
// mux that chooses between the seconds carry chain and manual INC steps for the min/hour strobes.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int REPEAT_DLY_MS  = 500,
    parameter int REPEAT_RATE_MS = 100,
    parameter int BLINK_MS       = 250,
    parameter int TIMEOUT_MS     = 10_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_mode_p,
    input  logic       key_inc_lvl,
    input  logic       min_flag_i,
    input  logic       hour_flag_i,
    output logic       min_flag_o,
    output logic       hour_inc_o,
    output logic       sec_run_o,
    output logic       sec_clr_o,
    output logic [1:0] mode_o,
    output logic       blink_on_o
);

    localparam int DIV   = MS_DIV(CLK_FREQ);
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MS_W  = $clog2(TIMEOUT_MS + 1);

    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
    localparam logic [MS_W-1:0]  TIMEOUT_C  = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0]  BLINK_LAST = MS_W'(BLINK_MS - 1);
    localparam logic [MS_W-1:0]  MS_ONE     = MS_W'(1);

    logic [PRE_W-1:0] pre_q;
    logic             ms_tick;
    logic [1:0]       mode_q, mode_d;
    logic             sec_clr_q;
    logic [MS_W-1:0]  idle_q, idle_d;
    logic [MS_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic             blink_q, blink_d;
    logic             man_inc;
    logic             inc_clr;

    assign ms_tick = (pre_q == PRE_MAX);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pre_q <= '0;
        end else if (ms_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_ONE;
        end
    end

    // A MODE press clears the stepper so a coincident INC edge is swallowed.
    assign inc_clr = (mode_q == MODE_RUN) || key_mode_p;

    key_autorepeat #(
        .REPEAT_DLY_MS (REPEAT_DLY_MS),
        .REPEAT_RATE_MS(REPEAT_RATE_MS),
        .CNT_W         (MS_W)
    ) u_key_autorepeat (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .ms_tick_i(ms_tick),
        .lvl_i    (key_inc_lvl),
        .clr_i    (inc_clr),
        .pulse_o  (man_inc)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= MODE_RUN;
            sec_clr_q <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            sec_clr_q <= (mode_q == MODE_RUN) && (mode_d == MODE_SET_HOUR);
        end
    end

    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            MODE_RUN: begin
                if (key_mode_p) mode_d = MODE_SET_HOUR;
            end
            MODE_SET_HOUR: begin
                if (key_mode_p) mode_d = MODE_SET_MIN;
                else if (idle_q == TIMEOUT_C && !key_inc_lvl) mode_d = MODE_RUN;
            end
            MODE_SET_MIN: begin
                if (key_mode_p) mode_d = MODE_RUN;
                else if (idle_q == TIMEOUT_C && !key_inc_lvl) mode_d = MODE_RUN;
            end
            default: mode_d = MODE_RUN;
        endcase
    end

    always_comb begin
        min_flag_o = 1'b0;
        hour_inc_o = 1'b0;
        sec_run_o  = 1'b0;
        case (mode_q)
            MODE_RUN: begin
                min_flag_o = min_flag_i & sys_rst_n;
                hour_inc_o = hour_flag_i & sys_rst_n;
                sec_run_o  = 1'b1;
            end
            MODE_SET_HOUR: hour_inc_o = man_inc;
            MODE_SET_MIN:  min_flag_o = man_inc;
            default: begin
                min_flag_o = 1'b0;
                hour_inc_o = 1'b0;
            end
        endcase
    end

    // Idle timer and blink phase both restart on any mode change; the timer saturates at the timeout.
    always_comb begin
        idle_d      = idle_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        if (mode_q == MODE_RUN || key_mode_p || key_inc_lvl || mode_d != mode_q) begin
            idle_d = '0;
        end else if (ms_tick && idle_q != TIMEOUT_C) begin
            idle_d = idle_q + MS_ONE;
        end
        if (mode_q == MODE_RUN || mode_d != mode_q || man_inc) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (ms_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + MS_ONE;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idle_q      <= '0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            idle_q      <= idle_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign mode_o     = mode_q;
    assign sec_clr_o  = sec_clr_q;
    assign blink_on_o = (mode_q == MODE_RUN) || blink_q || man_inc;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl with a 10 kHz clock so one ms tick is 10 cycles.
module tb_clock_set_ctrl;

    localparam int CLK_FREQ       = 10_000;
    localparam int REPEAT_DLY_MS  = 50;
    localparam int REPEAT_RATE_MS = 10;
    localparam int BLINK_MS       = 25;
    localparam int TIMEOUT_MS     = 1000;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       key_mode_p;
    logic       key_inc_lvl;
    logic       min_flag_i;
    logic       hour_flag_i;
    logic       min_flag_o;
    logic       hour_inc_o;
    logic       sec_run_o;
    logic       sec_clr_o;
    logic [1:0] mode_o;
    logic       blink_on_o;

    int assertCount = 0;
    int failCount   = 0;
    int cycleCnt;
    int minCount    = 0;
    int hourCount   = 0;
    int minTimes[$];

    clock_set_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .REPEAT_DLY_MS (REPEAT_DLY_MS),
        .REPEAT_RATE_MS(REPEAT_RATE_MS),
        .BLINK_MS      (BLINK_MS),
        .TIMEOUT_MS    (TIMEOUT_MS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_mode_p (key_mode_p),
        .key_inc_lvl(key_inc_lvl),
        .min_flag_i (min_flag_i),
        .hour_flag_i(hour_flag_i),
        .min_flag_o (min_flag_o),
        .hour_inc_o (hour_inc_o),
        .sec_run_o  (sec_run_o),
        .sec_clr_o  (sec_clr_o),
        .mode_o     (mode_o),
        .blink_on_o (blink_on_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Cycle index restarts with reset so it stays in phase with the DUT's ms prescaler.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) cycleCnt <= 0;
        else            cycleCnt <= cycleCnt + 1;
    end

    // Strobe monitor samples on the falling edge, tagging each strobe with the preceding rising edge.
    always @(negedge sys_clk) begin
        if (min_flag_o === 1'b1) begin
            minCount = minCount + 1;
            minTimes.push_back(cycleCnt);
        end
        if (hour_inc_o === 1'b1) hourCount = hourCount + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic modeP, input logic incLvl, input logic minF, input logic hourF);
        key_mode_p  = modeP;
        key_inc_lvl = incLvl;
        min_flag_i  = minF;
        hour_flag_i = hourF;
    endtask

    task automatic nextCycle();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sampleNeg();
        @(negedge sys_clk);
    endtask

    task automatic waitUntil(input int target);
        while (cycleCnt < target) nextCycle();
    endtask

    task automatic pulseMode();
        key_mode_p = 1'b1;
        nextCycle();
        key_mode_p = 1'b0;
    endtask

    function automatic int minTimeAt(input int idx);
        return (idx < minTimes.size()) ? minTimes[idx] : -1;
    endfunction

    initial begin
        int n;
        int e;
        int minBase;
        int hourBase;

        sys_rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        #2;
        checkOutput("rst_mode", mode_o, 0);
        checkOutput("rst_sec_run", sec_run_o, 1);
        checkOutput("rst_sec_clr", sec_clr_o, 0);
        checkOutput("rst_blink", blink_on_o, 1);
        checkOutput("rst_min_gate", min_flag_o, 0);
        checkOutput("rst_hour_gate", hour_inc_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #20 sys_rst_n = 1'b1;

        // RUN pass-through of the carry chain.
        waitUntil(99);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        sampleNeg();
        checkOutput("run_min_pass", min_flag_o, 1);
        checkOutput("run_hour_quiet", hour_inc_o, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        sampleNeg();
        checkOutput("run_min_drop", min_flag_o, 0);
        checkOutput("run_hour_pass", hour_inc_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sampleNeg();
        checkOutput("run_hour_drop", hour_inc_o, 0);

        // RUN -> SET_HOUR latency, seconds clear and stop.
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        sampleNeg();
        checkOutput("mode_reg_lat", mode_o, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sampleNeg();
        checkOutput("sethr_mode", mode_o, 1);
        checkOutput("sethr_sec_clr", sec_clr_o, 1);
        checkOutput("sethr_sec_run", sec_run_o, 0);
        checkOutput("sethr_blink", blink_on_o, 1);
        nextCycle();
        sampleNeg();
        checkOutput("sec_clr_once", sec_clr_o, 0);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        sampleNeg();
        checkOutput("sethr_chain_min", min_flag_o, 0);
        checkOutput("sethr_chain_hour", hour_inc_o, 0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        hourBase = hourCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        sampleNeg();
        checkOutput("sethr_step_hour", hour_inc_o, 1);
        checkOutput("sethr_step_min", min_flag_o, 0);
        repeat (10) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("sethr_step_count", hourCount - hourBase, 1);

        // SET_MIN entry and blink phase.
        pulseMode();
        n = cycleCnt;
        sampleNeg();
        checkOutput("setmin_mode", mode_o, 2);
        checkOutput("setmin_sec_clr", sec_clr_o, 0);
        checkOutput("setmin_sec_run", sec_run_o, 0);
        checkOutput("setmin_blink0", blink_on_o, 1);
        waitUntil(n + 240);
        sampleNeg();
        checkOutput("blink_still_on", blink_on_o, 1);
        waitUntil(n + 260);
        sampleNeg();
        checkOutput("blink_off", blink_on_o, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        sampleNeg();
        checkOutput("setmin_step_min", min_flag_o, 1);
        checkOutput("blink_forced", blink_on_o, 1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        sampleNeg();
        checkOutput("blink_restart", blink_on_o, 1);
        checkOutput("setmin_step_once", min_flag_o, 0);

        // INC held 800 cycles, press aligned to a ms tick; hour carry held high must never pass.
        nextCycle();
        while (cycleCnt % 10 != 9) nextCycle();
        minBase  = minCount;
        hourBase = hourCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        e = cycleCnt;
        repeat (799) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(e + 850);
        checkOutput("hold_count", minCount - minBase, 4);
        checkOutput("hold_t0", minTimeAt(minBase), e);
        checkOutput("hold_t1", minTimeAt(minBase + 1), e + 500);
        checkOutput("hold_t2", minTimeAt(minBase + 2), e + 600);
        checkOutput("hold_t3", minTimeAt(minBase + 3), e + 700);
        checkOutput("hold_no_hour", hourCount - hourBase, 0);

        pulseMode();
        sampleNeg();
        checkOutput("back_run_mode", mode_o, 0);
        checkOutput("back_run_sec_run", sec_run_o, 1);

        // Inactivity timeout from SET_HOUR.
        pulseMode();
        n = cycleCnt;
        sampleNeg();
        checkOutput("reentry_sec_clr", sec_clr_o, 1);
        waitUntil(n + 9990);
        sampleNeg();
        checkOutput("timeout_not_yet", mode_o, 1);
        waitUntil(n + 10002);
        sampleNeg();
        checkOutput("timeout_mode", mode_o, 0);
        checkOutput("timeout_sec_run", sec_run_o, 1);

        // INC press at 9000 restarts the timeout.
        pulseMode();
        n = cycleCnt;
        waitUntil(n + 8999);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        nextCycle();
        sampleNeg();
        checkOutput("late_step_hour", hour_inc_o, 1);
        waitUntil(n + 9004);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        waitUntil(n + 10500);
        sampleNeg();
        checkOutput("timeout_restart", mode_o, 1);
        waitUntil(n + 18990);
        sampleNeg();
        checkOutput("timeout2_not_yet", mode_o, 1);
        waitUntil(n + 19010);
        sampleNeg();
        checkOutput("timeout2_mode", mode_o, 0);

        // MODE coincident with INC edge: mode advances, step is discarded.
        pulseMode();
        repeat (5) nextCycle();
        minBase  = minCount;
        hourBase = hourCount;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        sampleNeg();
        checkOutput("simul_mode", mode_o, 2);
        checkOutput("simul_no_min", min_flag_o, 0);
        repeat (20) nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) nextCycle();
        checkOutput("simul_min_count", minCount - minBase, 0);
        checkOutput("simul_hour_count", hourCount - hourBase, 0);

        // Reset in SET_MIN while auto-repeat is running.
        minBase = minCount;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (560) nextCycle();
        checkOutput("pre_rst_repeat", minCount - minBase, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        checkOutput("midrst_mode", mode_o, 0);
        checkOutput("midrst_sec_run", sec_run_o, 1);
        checkOutput("midrst_min", min_flag_o, 0);
        checkOutput("midrst_hour", hour_inc_o, 0);
        checkOutput("midrst_blink", blink_on_o, 1);
        minBase  = minCount;
        hourBase = hourCount;
        repeat (3) sampleNeg();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        #2 sys_rst_n = 1'b1;
        repeat (600) nextCycle();
        checkOutput("postrst_mode", mode_o, 0);
        checkOutput("postrst_no_min", minCount - minBase, 0);
        checkOutput("postrst_no_hour", hourCount - hourBase, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
